// File: rtl/pll_phase_shift_controller.sv
// pll_phase_shift_controller
//   Steps the dynamic phase of one of two PLLs, one increment at a time. The
//   controller waits for the PLL's phasedone low-then-high handshake between
//   increments. It reports busy, done, dropped-request and timeout status back
//   to the command path.
//
// Parameters
//   STEP_HOLD : cycles phasestep is held high per step (>= 1)
//   TIMEOUT   : max cycles per step spent waiting for phasedone (>= 4)
//
// Ports
//   i_clk, i_rst_n               clock (also the PLL scanclk), async active-low reset
//   i_shift_ready                command strobe; rising edge = new command
//   i_periods_to_process         number of phase steps
//   i_phasecounterselect_1/2     counter select for PLL 1 / PLL 2
//   i_pll_to_update              0 = PLL 1, 1 = PLL 2
//   i_phaseupdown                direction, 1 = up
//   i_phasedone_1/2              PLL phasedone (asynchronous)
//   o_phasestep_1/2              phasestep to each PLL
//   o_phasecounterselect_1/2     counter select to each PLL
//   o_phaseupdown_1/2            direction to each PLL
//   o_busy                       command in progress
//   o_done                       one-cycle pulse on error-free completion
//   o_error                      sticky timeout flag, cleared by the next command
//   o_dropped                    one-cycle pulse when a request arrives while busy
//   o_steps_remaining            steps not yet completed
module pll_phase_shift_controller #(
    parameter int STEP_HOLD = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_shift_ready,
    input  logic [7:0] i_periods_to_process,
    input  logic [2:0] i_phasecounterselect_1,
    input  logic [2:0] i_phasecounterselect_2,
    input  logic       i_pll_to_update,
    input  logic       i_phaseupdown,
    input  logic       i_phasedone_1,
    input  logic       i_phasedone_2,
    output logic       o_phasestep_1,
    output logic       o_phasestep_2,
    output logic [2:0] o_phasecounterselect_1,
    output logic [2:0] o_phasecounterselect_2,
    output logic       o_phaseupdown_1,
    output logic       o_phaseupdown_2,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic       o_dropped,
    output logic [7:0] o_steps_remaining
);

    localparam int HW = (STEP_HOLD > 1) ? $clog2(STEP_HOLD) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(STEP_HOLD - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [2:0]    SEL_RST   = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STEP,
        WAIT_LOW,
        WAIT_HIGH,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic          shift_ready_q;
    logic [1:0]    sync_1, sync_2;
    logic          req, pd;

    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [TW-1:0] to_cnt, to_nxt;

    // latched command
    logic          pll, pll_nxt;
    logic          dir, dir_nxt;
    logic [2:0]    sel, sel_nxt;

    logic          step_1_nxt, step_2_nxt;
    logic [2:0]    cs_1_nxt, cs_2_nxt;
    logic          ud_1_nxt, ud_2_nxt;
    logic          busy_nxt, done_nxt, error_nxt, dropped_nxt;
    logic [7:0]    steps_nxt;
    logic          prog;

    assign req = i_shift_ready & ~shift_ready_q;
    assign pd  = pll ? sync_2[1] : sync_1[1];

    // phasedone synchronizers and request edge detect
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_1        <= '0;
            sync_2        <= '0;
            shift_ready_q <= 1'b0;
        end else begin
            sync_1        <= {sync_1[0], i_phasedone_1};
            sync_2        <= {sync_2[0], i_phasedone_2};
            shift_ready_q <= i_shift_ready;
        end
    end

    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        to_nxt      = to_cnt;
        pll_nxt     = pll;
        dir_nxt     = dir;
        sel_nxt     = sel;
        steps_nxt   = o_steps_remaining;
        error_nxt   = o_error;
        // busy drops the cycle after the done pulse
        busy_nxt    = o_busy & ~o_done;
        done_nxt    = (state == DONE);
        dropped_nxt = req & (state != IDLE);
        prog        = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    pll_nxt   = i_pll_to_update;
                    dir_nxt   = i_phaseupdown;
                    sel_nxt   = i_pll_to_update ? i_phasecounterselect_2 : i_phasecounterselect_1;
                    error_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                    steps_nxt = i_periods_to_process;
                    if (i_periods_to_process == 8'd0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SETUP;
                        prog      = 1'b1;
                    end
                end
            end
            SETUP: begin
                hold_nxt  = '0;
                to_nxt    = '0;
                state_nxt = STEP;
            end
            STEP: begin
                if (hold_cnt == HOLD_LAST) begin
                    hold_nxt  = '0;
                    state_nxt = WAIT_LOW;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            WAIT_LOW: begin
                to_nxt = to_cnt + 1'b1;
                if (!pd) begin
                    state_nxt = WAIT_HIGH;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = IDLE;
                    error_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            WAIT_HIGH: begin
                to_nxt = to_cnt + 1'b1;
                if (pd) begin
                    steps_nxt = o_steps_remaining - 8'd1;
                    if (o_steps_remaining == 8'd1) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SETUP;
                        prog      = 1'b1;
                    end
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = IDLE;
                    error_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Select/direction are registered on the edge that enters SETUP, so
        // they are already settled for the whole SETUP cycle before phasestep
        // rises on the edge that leaves it.
        cs_1_nxt = o_phasecounterselect_1;
        cs_2_nxt = o_phasecounterselect_2;
        ud_1_nxt = o_phaseupdown_1;
        ud_2_nxt = o_phaseupdown_2;
        if (prog) begin
            if (pll_nxt) begin
                cs_2_nxt = sel_nxt;
                ud_2_nxt = dir_nxt;
            end else begin
                cs_1_nxt = sel_nxt;
                ud_1_nxt = dir_nxt;
            end
        end

        // phasestep is a flop mirroring the STEP state, glitch-free at the pin
        step_1_nxt = (state_nxt == STEP) & ~pll_nxt;
        step_2_nxt = (state_nxt == STEP) &  pll_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state                  <= IDLE;
            hold_cnt               <= '0;
            to_cnt                 <= '0;
            pll                    <= 1'b0;
            dir                    <= 1'b1;
            sel                    <= SEL_RST;
            o_phasestep_1          <= 1'b0;
            o_phasestep_2          <= 1'b0;
            o_phasecounterselect_1 <= SEL_RST;
            o_phasecounterselect_2 <= SEL_RST;
            o_phaseupdown_1        <= 1'b1;
            o_phaseupdown_2        <= 1'b1;
            o_busy                 <= 1'b0;
            o_done                 <= 1'b0;
            o_error                <= 1'b0;
            o_dropped              <= 1'b0;
            o_steps_remaining      <= 8'd0;
        end else begin
            state                  <= state_nxt;
            hold_cnt               <= hold_nxt;
            to_cnt                 <= to_nxt;
            pll                    <= pll_nxt;
            dir                    <= dir_nxt;
            sel                    <= sel_nxt;
            o_phasestep_1          <= step_1_nxt;
            o_phasestep_2          <= step_2_nxt;
            o_phasecounterselect_1 <= cs_1_nxt;
            o_phasecounterselect_2 <= cs_2_nxt;
            o_phaseupdown_1        <= ud_1_nxt;
            o_phaseupdown_2        <= ud_2_nxt;
            o_busy                 <= busy_nxt;
            o_done                 <= done_nxt;
            o_error                <= error_nxt;
            o_dropped              <= dropped_nxt;
            o_steps_remaining      <= steps_nxt;
        end
    end

endmodule
